// File: rtl/out_port_arbiter_pkg.sv
// Shared NoC router definitions: port route codes, port count and arbiter states.
package out_port_arbiter_pkg;

    localparam int unsigned FLIT_W_DEF = 8;
    localparam int unsigned NUM_PORTS  = 5;

    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_N = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_W = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == PORT_W) ? PORT_L : 3'(i + 3'd1);
    endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational 5-way round-robin picker: first requester at or after ptr, wrapping 4->0.
module rr_pick
    import out_port_arbiter_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] onehot,
    output logic [2:0] idx,
    output logic       any
);

    int unsigned cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = (32'(ptr) + k) % NUM_PORTS;
            if (!any && req[cand[2:0]]) begin
                any                 = 1'b1;
                idx                 = cand[2:0];
                onehot[cand[2:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port wormhole arbiter: round-robin grant, packet-long hold, zero-latency flit mux.
// Optional stall timeout with forced release is enabled by defining ARB_TIMEOUT_EN.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int unsigned FLIT_W  = FLIT_W_DEF,
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            in_val,
    input  logic [14:0]           in_reg,
    input  logic [5*FLIT_W-1:0]   in_data,
    output logic [4:0]            in_ret,
    output logic                  out_val,
    output logic [FLIT_W-1:0]     out_data,
    input  logic                  out_ret,
    output logic [4:0]            grant,
    output logic                  err_timeout
);

    localparam logic [2:0] PORT_CODE = 3'(PORT_ID);
    localparam logic [3:0] LAST_CNT  = 4'(PKT_LEN - 1);

    arb_state_e state_q, state_d;
    logic [4:0] grant_q, grant_d;
    logic [2:0] gidx_q, gidx_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] flit_cnt_q, flit_cnt_d;

    logic [4:0] req;
    logic [4:0] pick_oh;
    logic [2:0] pick_idx;
    logic       pick_any;
    logic       xfer;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req[i] = in_val[i] && (in_reg[3*i +: 3] == PORT_CODE);
        end
    end

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        out_val  = 1'b0;
        out_data = '0;
        in_ret   = '0;
        if (state_q == XFER) begin
            out_val = in_val[gidx_q];
            if (out_val) begin
                out_data = in_data[32'(gidx_q) * FLIT_W +: FLIT_W];
            end
            in_ret[gidx_q] = out_ret && in_val[gidx_q];
        end
    end

    assign xfer  = out_val && out_ret;
    assign grant = grant_q;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
`ifdef ARB_TIMEOUT_EN
        stall_d    = stall_q;
        err_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_oh;
                    gidx_d     = pick_idx;
                    flit_cnt_d = '0;
                    state_d    = XFER;
`ifdef ARB_TIMEOUT_EN
                    stall_d    = '0;
`endif
                end
            end
            XFER: begin
                if (xfer) begin
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (flit_cnt_q == LAST_CNT) begin
                        grant_d    = '0;
                        rr_ptr_d   = next_idx(gidx_q);
                        flit_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        flit_cnt_d = flit_cnt_q + 4'd1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // A stall that reaches TIMEOUT cycles abandons the packet and moves the pointer on.
                else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    grant_d    = '0;
                    rr_ptr_d   = next_idx(gidx_q);
                    flit_cnt_d = '0;
                    state_d    = IDLE;
                    stall_d    = '0;
                    err_d      = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter (PORT_ID=2, PKT_LEN=4): packet-level reference model plus directed scenarios.
module tb_out_port_arbiter;

    localparam int unsigned FW  = 8;
    localparam int unsigned PID = 2;
    localparam int unsigned PL  = 4;
    localparam int unsigned TO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    in_val = '0;
    logic [14:0]   in_reg = '0;
    logic [39:0]   in_data = '0;
    logic          out_ret = 1'b0;
    logic [4:0]    in_ret;
    logic          out_val;
    logic [7:0]    out_data;
    logic [4:0]    grant;
    logic          err_timeout;

    out_port_arbiter #(
        .FLIT_W  (FW),
        .PORT_ID (PID),
        .PKT_LEN (PL),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_val      (in_val),
        .in_reg      (in_reg),
        .in_data     (in_data),
        .in_ret      (in_ret),
        .out_val     (out_val),
        .out_data    (out_data),
        .out_ret     (out_ret),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-input flit sources: each entry is {route[2:0], flit[7:0]}
    logic [10:0] srcq[5][$];
    logic [4:0]  drop = '0;
    logic [4:0]  take_n = '0;

    task automatic apply();
        logic [10:0] e;
        for (int i = 0; i < 5; i++) begin
            if (srcq[i].size() > 0) begin
                e = srcq[i][0];
                in_val[i]          = !drop[i];
                in_reg[3*i +: 3]   = e[10:8];
                in_data[8*i +: 8]  = e[7:0];
            end else begin
                in_val[i]          = 1'b0;
                in_reg[3*i +: 3]   = 3'd0;
                in_data[8*i +: 8]  = 8'd0;
            end
        end
    endtask

    task automatic push_pkt(input int i, input logic [2:0] r, input logic [31:0] d);
        for (int k = 0; k < 4; k++) srcq[i].push_back({r, d[31-8*k -: 8]});
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 5; i++) srcq[i].delete();
        drop = '0;
        apply();
    endtask

    always @(negedge clk) take_n = in_ret;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 5; i++) begin
            if (take_n[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        take_n = '0;
        apply();
    end

    // Reference model: who owns the port, how many flits of its packet have gone, whose turn is next.
    int   m_own = -1;
    int   m_sent = 0;
    int   m_ptr = 0;
    int   m_stall = 0;
    logic m_err = 1'b0;

    function automatic bit routes_here(input int i);
        return in_val[i] && (in_reg[3*i +: 3] == 3'(PID));
    endfunction

    always @(posedge clk or negedge rst) begin
        int j;
        if (!rst) begin
            m_own = -1; m_sent = 0; m_ptr = 0; m_stall = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_own < 0) begin
                for (int k = 0; k < 5; k++) begin
                    j = (m_ptr + k) % 5;
                    if (m_own < 0 && routes_here(j)) begin
                        m_own = j; m_sent = 0; m_stall = 0;
                    end
                end
            end else if (in_val[m_own] && out_ret) begin
                m_sent++;
                m_stall = 0;
                if (m_sent == PL) begin
                    m_ptr = (m_own + 1) % 5;
                    m_own = -1;
                end
            end else begin
`ifdef ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TO) begin
                    m_ptr = (m_own + 1) % 5;
                    m_own = -1;
                    m_err = 1'b1;
                end
`endif
            end
        end
    end

    logic [7:0] flits[$];
    logic [4:0] gq[$];
    int         gcyc[$];
    int         cyc = 0;
    int         n_err = 0;
    logic [4:0] prev_grant = '0;

    always @(negedge clk) begin
        logic [4:0] eg, er;
        logic       ev;
        logic [7:0] ed;
        int         o;
        cyc++;
        o  = (m_own < 0) ? 0 : m_own;
        eg = (m_own < 0) ? 5'd0 : 5'(1 << o);
        ev = (m_own >= 0) && in_val[o];
        ed = ev ? in_data[8*o +: 8] : 8'd0;
        er = (ev && out_ret) ? eg : 5'd0;
        check("grant", grant, eg);
        check("out_val", out_val, ev);
        check("out_data", out_data, ed);
        check("in_ret", in_ret, er);
        check("err_timeout", err_timeout, m_err);
        if (out_val && out_ret) flits.push_back(out_data);
        if (grant != 5'd0 && prev_grant == 5'd0) begin
            gq.push_back(grant);
            gcyc.push_back(cyc);
        end
        prev_grant = grant;
        if (err_timeout) n_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_flits(input int n, input int budget);
        int c = 0;
        while (flits.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_flits", 64'(flits.size() >= n), 64'd1);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (gq.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_grants", 64'(gq.size() >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_grant", grant, 5'd0);
        check("rst_out_val", out_val, 1'b0);
        check("rst_out_data", out_data, 8'd0);
        check("rst_in_ret", in_ret, 5'd0);
        check("rst_err", err_timeout, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Single request from N
        out_ret = 1'b1;
        flits.delete(); gq.delete(); gcyc.delete();
        push_pkt(1, 3'd2, 32'hAFFAF8F0);
        wait_flits(4, 20);
        tick(2);
        check("t1_f0", flits[0], 8'hAF);
        check("t1_f1", flits[1], 8'hFA);
        check("t1_f2", flits[2], 8'hF8);
        check("t1_f3", flits[3], 8'hF0);
        check("t1_grant", gq[0], 5'b00010);
        check("t1_idle", grant, 5'd0);

        // Route filter: input 2 addresses port 1
        srcq[2].push_back({3'd1, 8'h55});
        tick(20);
        check("filt_grant", grant, 5'd0);
        check("filt_ret", in_ret, 5'd0);
        clear_srcs();
        tick(1);

        // Async reset mid-packet
        flits.delete();
        push_pkt(1, 3'd2, 32'h11223344);
        wait_flits(2, 20);
        #1 rst = 1'b0;
        #1;
        check("arst_grant", grant, 5'd0);
        check("arst_out_val", out_val, 1'b0);
        check("arst_in_ret", in_ret, 5'd0);
        clear_srcs();
        #3 rst = 1'b1;
        tick(1);

        // Contention among 0, 3, 4 from pointer 0
        flits.delete(); gq.delete(); gcyc.delete();
        for (int p = 0; p < 2; p++) begin
            push_pkt(0, 3'd2, {8'h00, 8'(p), 8'hA0, 8'hA1});
            push_pkt(3, 3'd2, {8'h30, 8'(p), 8'hB0, 8'hB1});
            push_pkt(4, 3'd2, {8'h40, 8'(p), 8'hC0, 8'hC1});
        end
        wait_grants(4, 40);
        check("rr_g0", gq[0], 5'b00001);
        check("rr_g1", gq[1], 5'b01000);
        check("rr_g2", gq[2], 5'b10000);
        check("rr_g3", gq[3], 5'b00001);
        for (int k = 0; k < 3; k++) check("rr_spacing", 64'(gcyc[k+1] - gcyc[k]), 64'd5);
        wait_flits(24, 60);
        tick(2);

        // Backpressure, then a mid-packet valid drop, on input 4
        flits.delete();
        push_pkt(4, 3'd2, 32'hC1C2C3C4);
        wait_flits(1, 20);
        out_ret = 1'b0;
        tick(1);
        check("bp_val", out_val, 1'b1);
        check("bp_ret", in_ret, 5'd0);
        check("bp_data", out_data, 8'hC2);
        tick(2);
        check("bp_data_hold", out_data, 8'hC2);
        out_ret = 1'b1;
        wait_flits(2, 20);
        drop[4] = 1'b1;
        apply();
        tick(2);
        check("drop_grant", grant, 5'b10000);
        check("drop_val", out_val, 1'b0);
        drop[4] = 1'b0;
        apply();
        wait_flits(4, 20);
        tick(2);
        check("bp_f0", flits[0], 8'hC1);
        check("bp_f1", flits[1], 8'hC2);
        check("bp_f2", flits[2], 8'hC3);
        check("bp_f3", flits[3], 8'hC4);
        check("bp_idle", grant, 5'd0);

`ifdef ARB_TIMEOUT_EN
        // Stall timeout: input 1 abandoned, input 3 next
        #1 rst = 1'b0;
        out_ret = 1'b0;
        clear_srcs();
        #2 rst = 1'b1;
        tick(1);
        gq.delete(); gcyc.delete(); n_err = 0;
        push_pkt(1, 3'd2, 32'hD1D2D3D4);
        push_pkt(3, 3'd2, 32'hE1E2E3E4);
        wait_grants(2, 40);
        check("to_g0", gq[0], 5'b00010);
        check("to_g1", gq[1], 5'b01000);
        check("to_gap", 64'(gcyc[1] - gcyc[0]), 64'd17);
        check("to_err_count", 64'(n_err), 64'd1);
        clear_srcs();
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
